// File: rtl/mem_lsu_pkg.sv
// Shared constants, op codes and state encoding for the MEM-stage load/store unit.
package mem_lsu_pkg;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUSERR   = 2'b10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} lsu_state_e;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian byte-lane logic: load extract/extend, store lane select and data replication.
module mem_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [DATA_W-1:0] lbuf_i,
  output logic              misalign_o,
  output logic [3:0]        sel_o,
  output logic [DATA_W-1:0] st_wdata_o,
  output logic [DATA_W-1:0] ld_data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = lbuf_i[31:24];
      2'd1:    byte_v = lbuf_i[23:16];
      2'd2:    byte_v = lbuf_i[15:8];
      default: byte_v = lbuf_i[7:0];
    endcase
    half_v = addr_lo_i[1] ? lbuf_i[15:0] : lbuf_i[31:16];

    ld_data_o  = lbuf_i;
    sel_o      = 4'b1111;
    st_wdata_o = st_data_i;
    misalign_o = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin ld_data_o = {{24{byte_v[7]}}, byte_v};  sel_o = 4'b1000 >> addr_lo_i; end
      EXE_LBU_OP: begin ld_data_o = {24'h0, byte_v};            sel_o = 4'b1000 >> addr_lo_i; end
      EXE_LH_OP:  begin
        ld_data_o  = {{16{half_v[15]}}, half_v};
        sel_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        misalign_o = addr_lo_i[0];
      end
      EXE_LHU_OP: begin
        ld_data_o  = {16'h0, half_v};
        sel_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        misalign_o = addr_lo_i[0];
      end
      EXE_LW_OP:  misalign_o = |addr_lo_i;
      EXE_SB_OP:  begin st_wdata_o = {4{st_data_i[7:0]}}; sel_o = 4'b1000 >> addr_lo_i; end
      EXE_SH_OP:  begin
        st_wdata_o = {2{st_data_i[15:0]}};
        sel_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        misalign_o = addr_lo_i[0];
      end
      EXE_SW_OP:  misalign_o = |addr_lo_i;
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// MEM stage: passes ALU results through, and runs loads/stores as a stalled req/ack bus access.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic [OP_W-1:0]       aluop_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     reg2_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  stallreq_o,
  output logic                  mem_excp_o,
  output logic [1:0]            mem_excp_code_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_W-1:0]     bus_rdata_i
);
  lsu_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] lbuf_q, lbuf_d;
  logic              err_q, err_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;

  logic              misal, ld_op, st_op;
  logic [3:0]        al_sel;
  logic [DATA_W-1:0] al_wdata, al_ldata;

  assign ld_op = is_load(aluop_i);
  assign st_op = is_store(aluop_i);

  mem_align #(.DATA_W(DATA_W), .OP_W(OP_W)) u_align (
    .aluop_i   (aluop_i),
    .addr_lo_i (mem_addr_i[1:0]),
    .st_data_i (reg2_i),
    .lbuf_i    (lbuf_q),
    .misalign_o(misal),
    .sel_o     (al_sel),
    .st_wdata_o(al_wdata),
    .ld_data_o (al_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lbuf_q  <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lbuf_q  <= lbuf_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lbuf_d  = lbuf_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;

    wd_o            = wd_i;
    wreg_o          = wreg_i;
    wdata_o         = wdata_i;
    hi_o            = hi_i;
    lo_o            = lo_i;
    whilo_o         = whilo_i;
    stallreq_o      = 1'b0;
    mem_excp_o      = 1'b0;
    mem_excp_code_o = EXC_NONE;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (ld_op || st_op) begin
          wreg_o  = WriteDisable;
          whilo_o = WriteDisable;
          if (misal) begin
            mem_excp_o      = 1'b1;
            mem_excp_code_o = EXC_MISALIGN;
          end else begin
            stallreq_o = 1'b1;
            req_d      = 1'b1;
            we_d       = st_op;
            addr_d     = {mem_addr_i[ADDR_W-1:2], 2'b00};
            sel_d      = al_sel;
            wdat_d     = al_wdata;
            // Counter holds the number of WAIT cycles spent, starting at 1.
            cnt_d      = 8'd1;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stallreq_o = 1'b1;
        wreg_o     = WriteDisable;
        whilo_o    = WriteDisable;
        if (bus_ack_i) begin
          lbuf_d  = bus_rdata_i;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (ld_op) wdata_o = al_ldata;
        if (st_op) wreg_o = WriteDisable;
        if (err_q) begin
          mem_excp_o      = 1'b1;
          mem_excp_code_o = EXC_BUSERR;
          wreg_o          = WriteDisable;
          whilo_o         = WriteDisable;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst == RstEnable) begin
      wd_o            = NOPRegAddr;
      wreg_o          = WriteDisable;
      wdata_o         = ZeroWord;
      hi_o            = ZeroWord;
      lo_o            = ZeroWord;
      whilo_o         = WriteDisable;
      stallreq_o      = 1'b0;
      mem_excp_o      = 1'b0;
      mem_excp_code_o = EXC_NONE;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_sel_o   = sel_q;
  assign bus_wdata_o = wdat_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Randomised bench for mem_lsu with a behavioural big-endian memory-access model.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk, rst;
  logic [4:0]  wd_i, wd_o;
  logic        wreg_i, wreg_o, whilo_i, whilo_o;
  logic [31:0] wdata_i, hi_i, lo_i, wdata_o, hi_o, lo_o;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        stallreq_o, mem_excp_o;
  logic [1:0]  mem_excp_code_o;
  logic        bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;

  int nvec = 0;
  int nerr = 0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .stallreq_o(stallreq_o), .mem_excp_o(mem_excp_o), .mem_excp_code_o(mem_excp_code_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_mem_op(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP || op == EXE_LHU_OP ||
           op == EXE_LW_OP || op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] v;
    int lane;
    lane = int'(addr & 32'd3);
    v = w;
    if (op == EXE_LB_OP || op == EXE_LBU_OP) begin
      v = (w >> (8 * (3 - lane))) & 32'h0000_00FF;
      if (op == EXE_LB_OP && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (op == EXE_LH_OP || op == EXE_LHU_OP) begin
      v = (w >> ((lane >= 2) ? 0 : 16)) & 32'h0000_FFFF;
      if (op == EXE_LH_OP && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
    int lane;
    lane = int'(addr & 32'd3);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 4'(8 >> lane);
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return (lane >= 2) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] rt);
    if (op == EXE_SB_OP) return (rt & 32'hFF) * 32'h0101_0101;
    if (op == EXE_SH_OP) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  task automatic drive_nop();
    aluop_i = 8'h20; wreg_i = 1'b0; wd_i = '0; wdata_i = '0;
    hi_i = '0; lo_i = '0; whilo_i = 1'b0; mem_addr_i = '0; reg2_i = '0;
  endtask

  // Runs one aligned memory op from IDLE through DONE; delay==0 means ack never comes.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rdata, input int delay);
    int reqs, exp_reqs;
    logic st, dropped;
    logic [4:0] wd;
    st = (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP);
    exp_reqs = (delay == 0) ? 255 : delay;
    wd = 5'($urandom_range(1, 31));
    @(negedge clk);
    aluop_i = op; mem_addr_i = addr; reg2_i = rt; wreg_i = 1'b1; wd_i = wd;
    wdata_i = $urandom; whilo_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    nvec++;
    if ({stallreq_o, mem_excp_o} !== 2'b10) begin
      nerr++; $display("FAIL idle_stall op=%h stall/excp=%b expected 10", op, {stallreq_o, mem_excp_o});
    end
    reqs = 0; dropped = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!bus_req_o) begin dropped = 1'b1; break; end
      reqs++;
      if (reqs == 1) begin
        nvec++;
        if ({stallreq_o, bus_we_o, bus_addr_o, bus_sel_o} !== {1'b1, st, addr & 32'hFFFF_FFFC, ref_sel(op, addr)}) begin
          nerr++;
          $display("FAIL bus_fields op=%h got we=%b addr=%h sel=%b stall=%b expected we=%b addr=%h sel=%b stall=1",
                   op, bus_we_o, bus_addr_o, bus_sel_o, stallreq_o, st, addr & 32'hFFFF_FFFC, ref_sel(op, addr));
        end
        if (st) begin
          nvec++;
          if (bus_wdata_o !== ref_wdata(op, rt)) begin
            nerr++; $display("FAIL store_wdata op=%h got %h expected %h", op, bus_wdata_o, ref_wdata(op, rt));
          end
        end
      end
      if (reqs == delay) begin bus_ack_i = 1'b1; bus_rdata_i = rdata; end
    end
    bus_ack_i = 1'b0;
    nvec++;
    if (!dropped || reqs != exp_reqs) begin
      nerr++; $display("FAIL req_cycles op=%h got %0d (dropped=%b) expected %0d", op, reqs, dropped, exp_reqs);
    end
    #1;
    nvec++;
    if (delay == 0) begin
      if ({stallreq_o, mem_excp_o, mem_excp_code_o, wreg_o} !== {1'b0, 1'b1, EXC_BUSERR, 1'b0}) begin
        nerr++; $display("FAIL timeout_done stall=%b excp=%b code=%b wreg=%b expected 0 1 10 0",
                         stallreq_o, mem_excp_o, mem_excp_code_o, wreg_o);
      end
    end else if (st) begin
      if ({stallreq_o, mem_excp_o, wreg_o} !== 3'b000) begin
        nerr++; $display("FAIL store_done op=%h stall/excp/wreg=%b expected 000", op, {stallreq_o, mem_excp_o, wreg_o});
      end
    end else begin
      if ({stallreq_o, mem_excp_o, wreg_o, wd_o, wdata_o} !== {3'b001, wd, ref_load(op, addr, rdata)}) begin
        nerr++; $display("FAIL load_done op=%h addr=%h got stall=%b excp=%b wreg=%b wd=%0d wdata=%h expected 0 0 1 %0d %h",
                         op, addr, stallreq_o, mem_excp_o, wreg_o, wd_o, wdata_o, wd, ref_load(op, addr, rdata));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_ack_i = 1'b0; bus_rdata_i = '0;
    aluop_i = EXE_LW_OP; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = $urandom; hi_i = $urandom;
    lo_i = $urandom; whilo_i = 1'b1; mem_addr_i = 32'h40; reg2_i = $urandom;
    repeat (2) @(negedge clk);
    nvec++;
    if ({wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o, mem_excp_o, mem_excp_code_o} !== '0) begin
      nerr++; $display("FAIL reset_outputs wd=%0d wreg=%b wdata=%h hi=%h lo=%h whilo=%b stall=%b excp=%b expected all 0",
                       wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o, mem_excp_o);
    end
    nvec++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== '0) begin
      nerr++; $display("FAIL reset_bus req=%b we=%b addr=%h sel=%b wdata=%h expected all 0",
                       bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
    end
    drive_nop();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthru();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      aluop_i = 8'($urandom);
      if (is_mem_op(aluop_i)) aluop_i = 8'h20;
      if (i == 0) begin wreg_i = 1'b1; wd_i = 5'd5; wdata_i = 32'h1234; end
      else begin wreg_i = 1'($urandom); wd_i = 5'($urandom); wdata_i = $urandom; end
      hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom);
      mem_addr_i = $urandom; reg2_i = $urandom;
      #1;
      nvec++;
      if ({wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o, mem_excp_o, bus_req_o} !==
          {wd_i, wreg_i, wdata_i, hi_i, lo_i, whilo_i, 3'b000}) begin
        nerr++; $display("FAIL passthru op=%h got wd=%0d wreg=%b wdata=%h stall=%b req=%b expected wd=%0d wreg=%b wdata=%h stall=0 req=0",
                         aluop_i, wd_o, wreg_o, wdata_o, stallreq_o, bus_req_o, wd_i, wreg_i, wdata_i);
      end
    end
  endtask

  task automatic test_directed();
    run_mem(EXE_LW_OP,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
    run_mem(EXE_LB_OP,  32'h0000_0103, 32'h0, 32'h0000_00F0, 2);
    run_mem(EXE_LBU_OP, 32'h0000_0103, 32'h0, 32'h0000_00F0, 1);
    run_mem(EXE_SH_OP,  32'h0000_0202, 32'h0000_ABCD, 32'h0, 2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [8];
    logic [7:0] op;
    logic [31:0] addr;
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 7)];
      addr = $urandom;
      if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) addr = addr & 32'hFFFF_FFFE;
      if (op == EXE_LW_OP || op == EXE_SW_OP) addr = addr & 32'hFFFF_FFFC;
      run_mem(op, addr, $urandom, $urandom, $urandom_range(1, 6));
    end
  endtask

  task automatic test_misaligned();
    logic [7:0] ops [4];
    logic [31:0] addrs [4];
    ops = '{EXE_LW_OP, EXE_LH_OP, EXE_SW_OP, EXE_SH_OP};
    addrs = '{32'h101, 32'h203, 32'h302, 32'h405};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      aluop_i = ops[i]; mem_addr_i = addrs[i]; wreg_i = 1'b1; whilo_i = 1'b1; reg2_i = $urandom;
      #1;
      nvec++;
      if ({stallreq_o, mem_excp_o, mem_excp_code_o, wreg_o, whilo_o} !== {1'b0, 1'b1, EXC_MISALIGN, 2'b00}) begin
        nerr++; $display("FAIL misalign op=%h addr=%h stall=%b excp=%b code=%b wreg=%b whilo=%b expected 0 1 01 0 0",
                         aluop_i, mem_addr_i, stallreq_o, mem_excp_o, mem_excp_code_o, wreg_o, whilo_o);
      end
      @(negedge clk);
      drive_nop();
      #1;
      nvec++;
      if ({bus_req_o, mem_excp_o, stallreq_o} !== 3'b000) begin
        nerr++; $display("FAIL misalign_after req=%b excp=%b stall=%b expected 000", bus_req_o, mem_excp_o, stallreq_o);
      end
    end
  endtask

  task automatic test_timeout();
    run_mem(EXE_LW_OP, 32'h0000_0800, 32'h0, 32'h1111_2222, 0);
    run_mem(EXE_LW_OP, 32'h0000_0804, 32'h0, 32'h3333_4444, 2);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h900; wreg_i = 1'b1; wd_i = 5'd9; wdata_i = $urandom;
    hi_i = $urandom; lo_i = $urandom;
    repeat (4) @(negedge clk);
    nvec++;
    if (bus_req_o !== 1'b1) begin
      nerr++; $display("FAIL mid_wait_req got %b expected 1", bus_req_o);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o, mem_excp_o} !== '0) begin
      nerr++; $display("FAIL rst_mid_outputs wd=%0d wreg=%b wdata=%h stall=%b expected all 0", wd_o, wreg_o, wdata_o, stallreq_o);
    end
    @(negedge clk);
    nvec++;
    if (bus_req_o !== 1'b0) begin
      nerr++; $display("FAIL rst_mid_req got %b expected 0", bus_req_o);
    end
    drive_nop();
    wreg_i = 1'b1; wd_i = 5'd3; wdata_i = 32'h5555_AAAA;
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    #1;
    nvec++;
    if ({stallreq_o, wreg_o, wd_o, wdata_o} !== {1'b0, 1'b1, 5'd3, 32'h5555_AAAA}) begin
      nerr++; $display("FAIL late_ack_idle stall=%b wreg=%b wd=%0d wdata=%h expected 0 1 3 5555aaaa",
                       stallreq_o, wreg_o, wd_o, wdata_o);
    end
    @(negedge clk);
    bus_ack_i = 1'b0;
    nvec++;
    if ({bus_req_o, stallreq_o, mem_excp_o} !== 3'b000) begin
      nerr++; $display("FAIL late_ack_after req=%b stall=%b excp=%b expected 000", bus_req_o, stallreq_o, mem_excp_o);
    end
    run_mem(EXE_LHU_OP, 32'h0000_0A02, 32'h0, 32'h1234_8765, 1);
  endtask

  initial begin
    drive_nop();
    test_reset();
    test_passthru();
    test_directed();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
